// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - shared types for the pipelined Wishbone controller
package wishbone_pkg;

  typedef enum logic [1:0] {
    RSP_OK    = 2'd0,
    RSP_ERR   = 2'd1,
    RSP_RTY   = 2'd2,
    RSP_ABORT = 2'd3
  } rsp_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    FLUSH = 2'd2
  } wb_ctrl_state_t;

  // err wins over rty, rty wins over ack when a slave asserts several at once
  function automatic rsp_status_t term_status(input logic err, input logic rty);
    if (err) return RSP_ERR;
    if (rty) return RSP_RTY;
    return RSP_OK;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - Wishbone B4 pipelined bus signals with master/slave views
interface wishbone_if #(
  parameter  int ADR_WIDTH = 32,
  parameter  int DAT_WIDTH = 32,
  localparam int SEL_WIDTH = DAT_WIDTH / 8
);
  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [ADR_WIDTH-1:0] adr_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0] sel_o;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_i;
  logic                 err_i;
  logic                 rty_i;
  logic                 stall_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    input  dat_i, ack_i, err_i, rty_i, stall_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    output dat_i, ack_i, err_i, rty_i, stall_i
  );
endinterface

// File: rtl/wishbone_watchdog.sv
// rtl/wishbone_watchdog.sv - saturating no-termination cycle counter
module wishbone_watchdog #(
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int WD_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  logic [WD_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != WD_WIDTH'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + WD_WIDTH'(1);
    end
  end

  assign o_expired = (r_cnt == WD_WIDTH'(TIMEOUT_CYCLES));
endmodule

// File: rtl/wishbone_pipelined_controller.sv
// rtl/wishbone_pipelined_controller.sv - request stream to Wishbone pipelined cycles
// Slaves terminate in issue order, so responses are produced directly from terminations.
module wishbone_pipelined_controller
  import wishbone_pkg::*;
#(
  parameter  int ADR_WIDTH       = 32,
  parameter  int DAT_WIDTH       = 32,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int TIMEOUT_CYCLES  = 255,
  localparam int SEL_WIDTH       = DAT_WIDTH / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADR_WIDTH-1:0] req_adr_i,
  input  logic [DAT_WIDTH-1:0] req_dat_i,
  input  logic [SEL_WIDTH-1:0] req_sel_i,
  output logic                 rsp_valid_o,
  output logic [DAT_WIDTH-1:0] rsp_dat_o,
  output rsp_status_t          rsp_status_o,
  wishbone_if.master           wb
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  wb_ctrl_state_t       r_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_cyc;
  logic                 r_stb;
  logic                 r_we;
  logic [ADR_WIDTH-1:0] r_adr;
  logic [DAT_WIDTH-1:0] r_dat;
  logic [SEL_WIDTH-1:0] r_sel;
  logic                 r_rsp_valid;
  logic [DAT_WIDTH-1:0] r_rsp_dat;
  rsp_status_t          r_rsp_status;

  logic                 w_term;
  logic                 w_acc;
  logic                 w_abort;
  logic                 w_wd_expired;
  logic                 w_wd_clear;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  assign w_term = (wb.ack_i | wb.err_i | wb.rty_i) && (r_count != '0) && (r_state == BUS);

  // Gated by reset so the client never sees ready while the block is held in reset
  assign req_ready_o = rst_ni && (r_state != FLUSH) && (!r_stb || !wb.stall_i) &&
                       ((r_count - CNT_WIDTH'(w_term)) < CNT_WIDTH'(MAX_OUTSTANDING));
  assign w_acc       = req_valid_i && req_ready_o;
  assign w_cnt_nxt   = r_count + CNT_WIDTH'(w_acc) - CNT_WIDTH'(w_term);
  assign w_abort     = (r_state == BUS) && (w_term ? (wb.err_i || wb.rty_i) : w_wd_expired);
  assign w_wd_clear  = w_term || (r_count == '0) || (r_state != BUS);

  wishbone_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .i_clk     (clk_i),
    .i_rst_n   (rst_ni),
    .i_clear   (w_wd_clear),
    .i_enable  (r_state == BUS),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= RSP_OK;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= RSP_OK;
      if (w_acc) begin
        r_we  <= req_we_i;
        r_adr <= req_adr_i;
        r_dat <= req_dat_i;
        r_sel <= req_sel_i;
      end
      case (r_state)
        IDLE: begin
          r_count <= w_cnt_nxt;
          if (w_acc) begin
            r_state <= BUS;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
          end
        end
        BUS: begin
          r_count <= w_cnt_nxt;
          if (w_term) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= term_status(wb.err_i, wb.rty_i);
            if (!wb.err_i && !wb.rty_i) r_rsp_dat <= wb.dat_i;
          end
          if (w_abort) begin
            r_state <= FLUSH;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
          end else begin
            if (w_cnt_nxt == '0) begin
              r_state <= IDLE;
              r_cyc   <= 1'b0;
            end
            if (w_acc) r_stb <= 1'b1;
            else if (!wb.stall_i) r_stb <= 1'b0;
          end
        end
        FLUSH: begin
          // Every transfer still counted, including one never taken by the slave, reports ABORT
          if (r_count != '0) begin
            r_count      <= r_count - CNT_WIDTH'(1);
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= RSP_ABORT;
          end
          if ((r_count == '0) || (r_count == CNT_WIDTH'(1))) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb.cyc_o     = r_cyc;
  assign wb.stb_o     = r_stb;
  assign wb.we_o      = r_we;
  assign wb.adr_o     = r_adr;
  assign wb.dat_o     = r_dat;
  assign wb.sel_o     = r_sel;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_dat_o    = r_rsp_dat;
  assign rsp_status_o = r_rsp_status;
endmodule

// File: tb/tb_wishbone_pipelined_controller.sv
// tb/tb_wishbone_pipelined_controller.sv - scoreboard bench for the pipelined Wishbone controller
module tb_wishbone_pipelined_controller;
  import wishbone_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  rsp_status_t rsp_status;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  int n_acc, n_iss, n_ack;
  logic [33:0] exp_q[$];

  logic        g_acc, g_iss, g_ready, g_stb, g_cyc, g_rsp, g_we;
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;
  logic        ak, st;

  wishbone_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) wb();

  wishbone_pipelined_controller #(
    .ADR_WIDTH(32), .DAT_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_adr_i    (req_adr),
    .req_dat_i    (req_dat),
    .req_sel_i    (req_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_dat_o    (rsp_dat),
    .rsp_status_o (rsp_status),
    .wb           (wb)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [1:0] s, input logic [31:0] d);
    exp_q.push_back({s, d});
  endfunction

  task automatic set_req(input logic v, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    req_valid = v; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
  endtask

  task automatic set_bus(input logic a, input logic e, input logic r, input logic s,
                         input logic [31:0] di);
    wb.ack_i = a; wb.err_i = e; wb.rty_i = r; wb.stall_i = s; wb.dat_i = di;
  endtask

  // Sample the cycle's outputs, then advance to just after the next rising edge
  task automatic tick();
    #1;
    g_ready = req_ready;
    g_acc   = req_valid && req_ready;
    g_iss   = wb.stb_o && !wb.stall_i;
    g_stb   = wb.stb_o;
    g_cyc   = wb.cyc_o;
    g_we    = wb.we_o;
    g_adr   = wb.adr_o;
    g_dat   = wb.dat_o;
    g_sel   = wb.sel_o;
    g_rsp   = rsp_valid;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    if (rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got status %0d dat %0h, required no response", rsp_status, rsp_dat);
      end else begin
        e = exp_q.pop_front();
        check("rsp_status", 64'(rsp_status), 64'(e[33:32]));
        check("rsp_dat", 64'(rsp_dat), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_bus(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", wb.cyc_o, 0);
    check("rst_stb", wb.stb_o, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", req_ready, 1);

    // single read, ack two cycles after the strobe
    set_req(1, 0, 32'h1000, 0, 4'hF);
    tick();
    check("t1_ready", g_ready, 1);
    set_req(0, 0, 0, 0, 0);
    tick();
    check("t1_stb", g_stb, 1);
    check("t1_cyc", g_cyc, 1);
    check("t1_adr", g_adr, 32'h1000);
    check("t1_we", g_we, 0);
    tick();
    check("t1_stb_drop", g_stb, 0);
    set_bus(1, 0, 0, 0, 32'hDEADBEEF);
    push(RSP_OK, 32'hDEADBEEF);
    tick();
    set_bus(0, 0, 0, 0, 0);
    tick();
    check("t1_rsp", g_rsp, 1);
    check("t1_cyc_low", g_cyc, 0);
    repeat (2) tick();

    // six back-to-back writes, slave silent for five cycles
    n_acc = 0; n_iss = 0; n_ack = 0;
    for (int c = 0; c < 30 && n_ack < 6; c++) begin
      set_req(n_acc < 6, 1, 32'h100 + 4 * n_acc, 32'hA0 + n_acc, 4'hF);
      ak = (c >= 5) && (n_iss > n_ack);
      set_bus(ak, 0, 0, 0, ak ? 32'h5000 + n_ack : 32'h0);
      if (ak) push(RSP_OK, 32'h5000 + n_ack);
      tick();
      if (c == 4) begin
        check("t2_ready_full", g_ready, 0);
        check("t2_accepts_at_full", n_acc, 4);
      end
      if (c == 5) check("t2_ready_resume", g_ready, 1);
      if (g_iss) begin
        check("t2_issue_adr", g_adr, 32'h100 + 4 * n_iss);
        check("t2_issue_dat", g_dat, 32'hA0 + n_iss);
        n_iss++;
      end
      if (g_acc) n_acc++;
      if (ak) n_ack++;
    end
    check("t2_accepts", n_acc, 6);
    set_req(0, 0, 0, 0, 0);
    set_bus(0, 0, 0, 0, 0);
    repeat (2) tick();

    // stall held for three cycles on the second transfer
    n_acc = 0; n_iss = 0; n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      set_req(n_acc < 3, 1, 32'h200 + 4 * n_acc, 32'hB0 + n_acc, (n_acc == 1) ? 4'h3 : 4'hF);
      ak = ((c == 2) || (c >= 6)) && (n_iss > n_ack);
      st = (c >= 2) && (c <= 4);
      set_bus(ak, 0, 0, st, ak ? 32'h3000 + n_ack : 32'h0);
      if (ak) push(RSP_OK, 32'h3000 + n_ack);
      tick();
      if (c >= 2 && c <= 4) begin
        check("t3_stall_ready", g_ready, 0);
        check("t3_hold_stb", g_stb, 1);
        check("t3_hold_adr", g_adr, 32'h204);
        check("t3_hold_dat", g_dat, 32'hB1);
        check("t3_hold_sel", g_sel, 4'h3);
      end
      if (g_iss) n_iss++;
      if (g_acc) n_acc++;
      if (ak) n_ack++;
    end
    check("t3_issues", n_iss, 3);
    check("t3_accepts", n_acc, 3);
    set_req(0, 0, 0, 0, 0);
    set_bus(0, 0, 0, 0, 0);
    repeat (2) tick();

    // err on the oldest of three outstanding reads
    n_acc = 0;
    for (int c = 0; c < 9; c++) begin
      set_req((c < 3) || (c == 4) || (c == 5), 0, 32'h300 + 4 * c, 0, 4'hF);
      if (c == 3) begin
        set_bus(0, 1, 0, 0, 32'hFFFF_FFFF);
        push(RSP_ERR, 0);
        push(RSP_ABORT, 0);
        push(RSP_ABORT, 0);
      end else begin
        set_bus(0, 0, 0, 0, 0);
      end
      tick();
      if (g_acc) n_acc++;
      if (c == 4) begin
        check("t4_cyc_drop", g_cyc, 0);
        check("t4_stb_drop", g_stb, 0);
        check("t4_ready_flush0", g_ready, 0);
        check("t4_rsp_err", g_rsp, 1);
      end
      if (c == 5) begin
        check("t4_ready_flush1", g_ready, 0);
        check("t4_rsp_abort0", g_rsp, 1);
      end
      if (c == 6) check("t4_rsp_abort1", g_rsp, 1);
      if (c == 7) check("t4_rsp_quiet", g_rsp, 0);
    end
    check("t4_accepts", n_acc, 3);
    set_req(0, 0, 0, 0, 0);
    repeat (2) tick();

    // read never acknowledged, watchdog limit of eight cycles
    for (int c = 0; c < 16; c++) begin
      set_req((c == 0) || (c == 11), 0, (c == 0) ? 32'h400 : 32'h480, 0, 4'hF);
      ak = (c == 13);
      set_bus(ak, 0, 0, 0, ak ? 32'h1234_5678 : 32'h0);
      if (c == 0) push(RSP_ABORT, 0);
      if (ak) push(RSP_OK, 32'h1234_5678);
      tick();
      if (c == 9)  check("t5_cyc_before", g_cyc, 1);
      if (c == 10) check("t5_cyc_drop", g_cyc, 0);
      if (c == 11) begin
        check("t5_abort_rsp", g_rsp, 1);
        check("t5_ready_after", g_ready, 1);
      end
      if (c == 12) begin
        check("t5_new_stb", g_stb, 1);
        check("t5_new_adr", g_adr, 32'h480);
      end
      if (c == 14) check("t5_new_rsp", g_rsp, 1);
    end
    set_req(0, 0, 0, 0, 0);
    repeat (2) tick();

    // asynchronous reset with two writes in flight
    set_req(1, 1, 32'h600, 32'h66, 4'hF);
    tick();
    set_req(1, 1, 32'h604, 32'h67, 4'hF);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_cyc", wb.cyc_o, 0);
    check("t6_stb", wb.stb_o, 0);
    check("t6_we", wb.we_o, 0);
    check("t6_adr", wb.adr_o, 0);
    check("t6_dat", wb.dat_o, 0);
    check("t6_sel", wb.sel_o, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_dat", rsp_dat, 0);
    check("t6_rsp_status", 64'(rsp_status), 0);
    check("t6_ready", req_ready, 0);
    @(posedge clk);
    #1;
    set_req(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    set_bus(1, 0, 0, 0, 32'hBAD);
    tick();
    set_bus(0, 0, 0, 0, 0);
    tick();
    check("t6_spurious_rsp", g_rsp, 0);
    check("t6_spurious_cyc", g_cyc, 0);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    check("rsp_total", n_rsp, 15);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
